vector_writeback_regfile: RTL

VECTOR_WRITEBACK_REGFILE -- requirements
Module: vector_writeback_regfile

---
 rtl/vector_writeback_regfile_if.sv | 28 ++
 rtl/vector_writeback_regfile.sv | 73 +++++++
 2 files changed

// File: rtl/vector_writeback_regfile_if.sv
// Writeback/decode bus for vector_writeback_regfile: result sources, write control,
// read addresses and read/result data. Master drives the pipe side, slave is the regfile.
interface vector_writeback_regfile_if #(
   parameter int N = 8
);
   logic                  cargar;
   logic [15:0][N-1:0]    RDM;
   logic [15:0][N-1:0]    ALUOutM;
   logic                  RegWriteM;
   logic                  MemtoRegM;
   logic [3:0]            WA3M;
   logic [3:0]            RA1;
   logic [3:0]            RA2;
   logic [15:0][N-1:0]    RD1;
   logic [15:0][N-1:0]    RD2;
   logic [15:0][N-1:0]    ResultW;
   logic [15:0]           WrittenMask;

   modport master (
      output cargar, RDM, ALUOutM, RegWriteM, MemtoRegM, WA3M, RA1, RA2,
      input  RD1, RD2, ResultW, WrittenMask
   );

   modport slave (
      input  cargar, RDM, ALUOutM, RegWriteM, MemtoRegM, WA3M, RA1, RA2,
      output RD1, RD2, ResultW, WrittenMask
   );
endinterface

// File: rtl/vector_writeback_regfile.sv
// 16 x 16-lane vector register file with writeback result select and written-mask.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writes to RD1/RD2.
module vector_writeback_regfile #(
   parameter int N = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   vector_writeback_regfile_if.slave bus
);
   typedef logic [15:0][N-1:0] vec_t;

   vec_t        regs_r [16];
   logic [15:0] written_r;
   vec_t        result_s;
   vec_t        rd1_s;
   vec_t        rd2_s;
   logic        wr_en_s;

   // Result select is independent of the write enable; it drives ResultW every cycle.
   always_comb begin
      result_s = bus.ALUOutM;
      if (bus.MemtoRegM) begin
         result_s = bus.RDM;
      end else begin
         result_s = bus.ALUOutM;
      end
      wr_en_s = bus.cargar & bus.RegWriteM;
   end

   // Register storage and written-mask; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            regs_r[i] <= '0;
         end
         written_r <= 16'h0000;
      end else if (wr_en_s) begin
         regs_r[bus.WA3M]    <= result_s;
         written_r[bus.WA3M] <= 1'b1;
      end else begin
         written_r <= written_r;
      end
   end

   // Asynchronous read ports, optionally forwarding the in-flight result.
   always_comb begin
      rd1_s = regs_r[bus.RA1];
      rd2_s = regs_r[bus.RA2];
`ifdef WB_REGFILE_BYPASS_EN
      if (wr_en_s && (bus.RA1 == bus.WA3M)) begin
         rd1_s = result_s;
      end else begin
         rd1_s = regs_r[bus.RA1];
      end
      if (wr_en_s && (bus.RA2 == bus.WA3M)) begin
         rd2_s = result_s;
      end else begin
         rd2_s = regs_r[bus.RA2];
      end
`else
      if (wr_en_s) begin
         rd1_s = regs_r[bus.RA1];
      end else begin
         rd1_s = regs_r[bus.RA1];
      end
`endif
   end

   assign bus.RD1         = rd1_s;
   assign bus.RD2         = rd2_s;
   assign bus.ResultW     = result_s;
   assign bus.WrittenMask = written_r;
endmodule
